// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Captures decoded operands and controls and presents them to EX.
// Detects the lw -> dependent-instruction hazard that forwarding cannot cover.
// On that hazard it holds PC and IF/ID for one cycle and inserts a bubble.
// A branch/jump flush squashes the ID instruction and takes priority over a stall.

module id_ex_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_UsesRt,
    input  logic [4:0]        ID_WriteReg,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [DATA_W-1:0] ID_A,
    input  logic [DATA_W-1:0] ID_B,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic              Flush,
    output logic              PcWrite,
    output logic              IfIdWrite,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [4:0]        EX_WriteReg,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [DATA_W-1:0] EX_A,
    output logic [DATA_W-1:0] EX_B,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [CNT_W-1:0]  StallCount
);

    // Position of MemRead inside the control bundle.
    localparam int MEM_READ_BIT = 1;

    logic hazard;
    logic stall;
    logic bubble;

    // Load-use detection: a load in EX whose nonzero destination is read by the ID instruction.
    always_comb begin
        hazard = 1'b0;
        if (EX_Ctrl[MEM_READ_BIT] && (EX_WriteReg != 5'd0)) begin
            hazard = (EX_WriteReg == ID_rs) || (ID_UsesRt && (EX_WriteReg == ID_rt));
        end
    end

    // A taken branch discards the ID instruction anyway, so it never needs to be held.
    assign stall     = hazard && !Flush;
    assign bubble    = hazard || Flush;
    assign PcWrite   = !stall;
    assign IfIdWrite = !stall;

    // Pipeline register: zero everything for a bubble so EX never writes, accesses memory or forwards.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_rs       <= '0;
            EX_rt       <= '0;
            EX_WriteReg <= '0;
            EX_Ctrl     <= '0;
            EX_A        <= '0;
            EX_B        <= '0;
            EX_Imm      <= '0;
        end else if (bubble) begin
            EX_rs       <= '0;
            EX_rt       <= '0;
            EX_WriteReg <= '0;
            EX_Ctrl     <= '0;
            EX_A        <= '0;
            EX_B        <= '0;
            EX_Imm      <= '0;
        end else begin
            EX_rs       <= ID_rs;
            EX_rt       <= ID_rt;
            EX_WriteReg <= ID_WriteReg;
            EX_Ctrl     <= ID_Ctrl;
            EX_A        <= ID_A;
            EX_B        <= ID_B;
            EX_Imm      <= ID_Imm;
        end
    end

    // Performance counter of load-use stall cycles; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg.
// A reference model predicts the EX register contents after every edge; predictions are
// queued when stimulus is applied and compared one edge later by a scoreboard process.
// Scenario tasks add direct checks of the stall outputs and of specific EX values.
// A second instance with a 4-bit counter exercises counter saturation in few cycles.

module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [7:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [15:0] cnt;
    } ex_t;

    localparam logic [7:0] C_LW  = 8'h0B; // RegWrite | MemRead | MemToReg
    localparam logic [7:0] C_ADD = 8'h41; // RegWrite, ALUOp=2
    localparam logic [7:0] C_SW  = 8'h14; // MemWrite | ALUSrc

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_wr;
    logic        id_uses_rt, flush;
    logic [7:0]  id_ctrl;
    logic [31:0] id_a, id_b, id_imm;

    logic        pc_write, ifid_write;
    logic [4:0]  ex_rs, ex_rt, ex_wr;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] stall_count;

    logic        s_pc_write, s_ifid_write;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_wr;
    logic [7:0]  s_ex_ctrl;
    logic [31:0] s_ex_a, s_ex_b, s_ex_imm;
    logic [3:0]  s_stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    ex_t model;
    ex_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_WriteReg(id_wr),
        .ID_Ctrl(id_ctrl), .ID_A(id_a), .ID_B(id_b), .ID_Imm(id_imm), .Flush(flush),
        .PcWrite(pc_write), .IfIdWrite(ifid_write),
        .EX_rs(ex_rs), .EX_rt(ex_rt), .EX_WriteReg(ex_wr), .EX_Ctrl(ex_ctrl),
        .EX_A(ex_a), .EX_B(ex_b), .EX_Imm(ex_imm), .StallCount(stall_count)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_WriteReg(id_wr),
        .ID_Ctrl(id_ctrl), .ID_A(id_a), .ID_B(id_b), .ID_Imm(id_imm), .Flush(flush),
        .PcWrite(s_pc_write), .IfIdWrite(s_ifid_write),
        .EX_rs(s_ex_rs), .EX_rt(s_ex_rt), .EX_WriteReg(s_ex_wr), .EX_Ctrl(s_ex_ctrl),
        .EX_A(s_ex_a), .EX_B(s_ex_b), .EX_Imm(s_ex_imm), .StallCount(s_stall_count)
    );

    // Scoreboard: one edge after each issue, the EX register must equal the prediction.
    always @(posedge clk) begin
        ex_t exp_v, got_v;
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            got_v = {ex_rs, ex_rt, ex_wr, ex_ctrl, ex_a, ex_b, ex_imm, stall_count};
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL sb_ex_reg: got rs=%0d rt=%0d wr=%0d ctrl=%h a=%h b=%h imm=%h cnt=%0d expected rs=%0d rt=%0d wr=%0d ctrl=%h a=%h b=%h imm=%h cnt=%0d",
                         got_v.rs, got_v.rt, got_v.wr, got_v.ctrl, got_v.a, got_v.b, got_v.imm, got_v.cnt,
                         exp_v.rs, exp_v.rt, exp_v.wr, exp_v.ctrl, exp_v.a, exp_v.b, exp_v.imm, exp_v.cnt);
            else
                n_pass++;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running after 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic model_hazard(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
        return model.ctrl[1] && (model.wr != 5'd0) && ((model.wr == rs) || (uses_rt && (model.wr == rt)));
    endfunction

    // Apply one ID instruction (called 2 time units after a rising edge) and queue its prediction.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic [4:0] wr, input logic [7:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic fl);
        ex_t nxt;
        logic haz;
        id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_wr = wr;
        id_ctrl = ctrl; id_a = a; id_b = b; id_imm = imm; flush = fl;
        #1;
        haz = model_hazard(rs, rt, uses_rt);
        nxt = '0;
        if (!(haz || fl)) begin
            nxt.rs = rs; nxt.rt = rt; nxt.wr = wr; nxt.ctrl = ctrl;
            nxt.a = a; nxt.b = b; nxt.imm = imm;
        end
        nxt.cnt = model.cnt;
        if (haz && !fl && (model.cnt != 16'hFFFF))
            nxt.cnt = model.cnt + 16'd1;
        sb.push_back(nxt);
        model = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_nop();
        issue(5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Garbage on the ID side must not reach EX while reset is held.
        id_rs = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1; id_wr = 5'd4; id_ctrl = C_LW;
        id_a = 32'hDEAD_BEEF; id_b = 32'h1234_5678; id_imm = 32'hFFFF_0000; flush = 1'b0;
        #3;
        n_checks++;
        if ({ex_rs, ex_rt, ex_wr, ex_ctrl, ex_a, ex_b, ex_imm, stall_count} !== '0)
            $display("FAIL reset_outputs: got ctrl=%h a=%h cnt=%0d expected all zero", ex_ctrl, ex_a, stall_count);
        else n_pass++;
        n_checks++;
        if ({pc_write, ifid_write} !== 2'b11)
            $display("FAIL reset_pcwrite: got %b expected 11", {pc_write, ifid_write});
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({ex_ctrl, ex_wr} !== '0)
            $display("FAIL reset_held_edge: got ctrl=%h wr=%0d expected 0", ex_ctrl, ex_wr);
        else n_pass++;
        #1;
        rst = 1'b0;
        model = '0;
        sb.delete();
        #1;
        n_checks++;
        if (pc_write !== 1'b1)
            $display("FAIL reset_release_pcwrite: got %b expected 1", pc_write);
        else n_pass++;
        tick();
    endtask

    task automatic test_pass_through();
        issue(5'd1, 5'd2, 1'b1, 5'd3, 8'h01, 32'd5, 32'd7, 32'd0, 1'b0);
        n_checks++;
        if (pc_write !== 1'b1) $display("FAIL pass_pcwrite: got %b expected 1", pc_write);
        else n_pass++;
        tick();
        n_checks++;
        if ({ex_rs, ex_rt, ex_wr, ex_a, ex_b} !== {5'd1, 5'd2, 5'd3, 32'd5, 32'd7})
            $display("FAIL pass_add: got rs=%0d rt=%0d wr=%0d a=%0d b=%0d expected 1 2 3 5 7",
                     ex_rs, ex_rt, ex_wr, ex_a, ex_b);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            issue(5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)),
                  5'($urandom_range(31)), 8'($urandom) & 8'hFD, $urandom, $urandom, $urandom, 1'b0);
            n_checks++;
            if ({pc_write, ifid_write} !== 2'b11)
                $display("FAIL pass_random_pcwrite: got %b expected 11", {pc_write, ifid_write});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_load_use();
        issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd100, 32'd0, 32'd8, 1'b0);
        tick();
        issue(5'd4, 5'd6, 1'b1, 5'd5, C_ADD, 32'd11, 32'd22, 32'd0, 1'b0);
        n_checks++;
        if ({pc_write, ifid_write} !== 2'b00)
            $display("FAIL load_use_stall: got %b expected 00", {pc_write, ifid_write});
        else n_pass++;
        tick();
        n_checks++;
        if (ex_ctrl !== 8'h00) $display("FAIL load_use_bubble: got ctrl=%h expected 00", ex_ctrl);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd1) $display("FAIL load_use_count: got %0d expected 1", stall_count);
        else n_pass++;
        issue(5'd4, 5'd6, 1'b1, 5'd5, C_ADD, 32'd11, 32'd22, 32'd0, 1'b0);
        n_checks++;
        if (pc_write !== 1'b1) $display("FAIL load_use_release: got %b expected 1", pc_write);
        else n_pass++;
        tick();
        n_checks++;
        if ({ex_rs, ex_wr, ex_ctrl} !== {5'd4, 5'd5, C_ADD})
            $display("FAIL load_use_advance: got rs=%0d wr=%0d ctrl=%h expected 4 5 %h", ex_rs, ex_wr, ex_ctrl, C_ADD);
        else n_pass++;
    endtask

    task automatic test_rt_gating();
        issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd0, 32'd0, 32'd4, 1'b0);
        tick();
        issue(5'd7, 5'd4, 1'b0, 5'd4, 8'h11, 32'd3, 32'd0, 32'd9, 1'b0);
        n_checks++;
        if (pc_write !== 1'b1) $display("FAIL rt_unused_no_stall: got %b expected 1", pc_write);
        else n_pass++;
        tick();
        issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd0, 32'd0, 32'd4, 1'b0);
        tick();
        issue(5'd7, 5'd4, 1'b1, 5'd9, C_ADD, 32'd3, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (ifid_write !== 1'b0) $display("FAIL rt_used_stall: got %b expected 0", ifid_write);
        else n_pass++;
        tick();
        issue_nop();
        tick();
    endtask

    task automatic test_zero_store();
        issue(5'd1, 5'd0, 1'b0, 5'd0, C_LW, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        issue(5'd0, 5'd0, 1'b1, 5'd2, C_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (pc_write !== 1'b1) $display("FAIL lw_zero_no_stall: got %b expected 1", pc_write);
        else n_pass++;
        tick();
        issue(5'd1, 5'd8, 1'b1, 5'd8, C_SW, 32'd0, 32'd0, 32'd4, 1'b0);
        tick();
        issue(5'd8, 5'd8, 1'b1, 5'd3, C_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (pc_write !== 1'b1) $display("FAIL store_no_stall: got %b expected 1", pc_write);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        issue(5'd4, 5'd6, 1'b1, 5'd5, C_ADD, 32'd1, 32'd2, 32'd0, 1'b1);
        n_checks++;
        if ({pc_write, ifid_write} !== 2'b11)
            $display("FAIL flush_no_stall: got %b expected 11", {pc_write, ifid_write});
        else n_pass++;
        tick();
        n_checks++;
        if ({ex_ctrl, stall_count} !== {8'h00, 16'd2})
            $display("FAIL flush_bubble: got ctrl=%h cnt=%0d expected 00 2", ex_ctrl, stall_count);
        else n_pass++;
        flush = 1'b0;
        issue_nop();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        issue(5'd4, 5'd6, 1'b1, 5'd5, C_ADD, 32'd1, 32'd2, 32'd0, 1'b0);
        n_checks++;
        if (pc_write !== 1'b0) $display("FAIL mid_stall_pre: got %b expected 0", pc_write);
        else n_pass++;
        #1;
        rst = 1'b1;
        sb.delete();
        model = '0;
        #1;
        n_checks++;
        if ({pc_write, ifid_write} !== 2'b11)
            $display("FAIL mid_stall_pcwrite: got %b expected 11", {pc_write, ifid_write});
        else n_pass++;
        n_checks++;
        if ({ex_rs, ex_rt, ex_wr, ex_ctrl, ex_a, ex_b, ex_imm, stall_count} !== '0)
            $display("FAIL mid_stall_clear: got wr=%0d ctrl=%h cnt=%0d expected all zero", ex_wr, ex_ctrl, stall_count);
        else n_pass++;
        tick();
        rst = 1'b0;
        issue_nop();
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            issue(5'd1, 5'd4, 1'b0, 5'd4, C_LW, 32'd0, 32'd0, 32'd0, 1'b0);
            tick();
            issue(5'd4, 5'd0, 1'b0, 5'd5, C_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
            tick();
            if (i == 13) begin
                n_checks++;
                if (s_stall_count !== 4'hE) $display("FAIL sat_before: got %h expected e", s_stall_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (s_stall_count !== 4'hF) $display("FAIL sat_hold: got %h expected f", s_stall_count);
        else n_pass++;
        n_checks++;
        if (stall_count !== 16'd20) $display("FAIL sat_wide_count: got %0d expected 20", stall_count);
        else n_pass++;
        issue_nop();
        tick();
    endtask

    initial begin
        model = '0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_rt_gating();
        test_zero_store();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        tick();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
